// File: rtl/sdram_read.sv
// -----------------------------------------------------------------------------
// sdram_read
//   SDRAM read engine. A job reads rows 0 and 1 of bank 0, 512 words each, as
//   256 bursts (BL=4, CL=3). The bus is requested from an arbiter. Pending
//   refresh requests are honoured only at burst boundaries. When that happens
//   the row is precharged, the bus is released and re-requested, and the job
//   resumes at the next unread burst.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   rd_trig       pulse: start a job (ignored unless idle)
//   rd_en         bus grant from the arbiter
//   ref_req       refresh pending; checked at the end of each burst slot
//   rd_dq         SDRAM DQ input
//   rd_req        bus request, high exactly while waiting for the grant
//   flag_rd_end   one-cycle pulse when the bus is handed back
//   rd_cmd        registered {CS,RAS,CAS,WE}
//   rd_addr       registered A[11:0]
//   bank_addr     constant bank 0
//   rd_data       captured read word
//   rd_data_vld   rd_data qualifier, four beats per burst
// -----------------------------------------------------------------------------
module sdram_read (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_trig,
  input  logic        rd_en,
  input  logic        ref_req,
  input  logic [15:0] rd_dq,
  output logic        rd_req,
  output logic        flag_rd_end,
  output logic [3:0]  rd_cmd,
  output logic [11:0] rd_addr,
  output logic [1:0]  bank_addr,
  output logic [15:0] rd_data,
  output logic        rd_data_vld
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_REQ   = 5'b00010,
    S_ACT   = 5'b00100,
    S_READ  = 5'b01000,
    S_BREAK = 5'b10000
  } state_t;

  localparam logic [3:0]  CMD_NOP   = 4'b0111;
  localparam logic [3:0]  CMD_ACT   = 4'b0011;
  localparam logic [3:0]  CMD_RD    = 4'b0101;
  localparam logic [3:0]  CMD_PRE   = 4'b0010;
  localparam logic [11:0] ADDR_NOP  = 12'h400;  // A10 high: PRE closes all banks
  localparam logic [11:0] ROW_END   = 12'd2;    // first row past the job
  localparam int          RD_PIPE   = 5;        // RD-to-last-capture tracking depth

  state_t              state_q, state_d;
  logic [1:0]          act_cnt_q, act_cnt_d;
  logic [1:0]          burst_cnt_q, burst_cnt_d;
  logic [2:0]          break_cnt_q, break_cnt_d;
  logic [11:0]         row_addr_q, row_addr_d;
  logic [8:0]          col_addr_q, col_addr_d;
  logic                ref_pend_q, ref_pend_d;
  logic                job_done_q, job_done_d;
  logic [3:0]          rd_cmd_q, rd_cmd_d;
  logic [11:0]         rd_addr_q, rd_addr_d;
  logic                rd_req_q, rd_req_d;
  logic                flag_q, flag_d;
  logic [RD_PIPE:0]    vld_pipe_q, vld_pipe_d;
  logic [15:0]         rd_data_q, rd_data_d;
  logic                rd_vld_q, rd_vld_d;
  logic                cap_en;
  logic                row_wrapped, all_read;

  // col_addr has already advanced past the burst by burst_cnt=3, so a zero
  // column means the last column of a row was just read.
  assign row_wrapped = (col_addr_q == 9'd0);
  assign all_read    = (row_addr_q == ROW_END) && row_wrapped;

  always_comb begin
    state_d     = state_q;
    act_cnt_d   = act_cnt_q;
    burst_cnt_d = burst_cnt_q;
    break_cnt_d = break_cnt_q;
    row_addr_d  = row_addr_q;
    col_addr_d  = col_addr_q;
    ref_pend_d  = ref_pend_q;
    job_done_d  = job_done_q;
    rd_cmd_d    = CMD_NOP;
    rd_addr_d   = ADDR_NOP;
    flag_d      = 1'b0;
    unique case (state_q)
      S_IDLE: if (rd_trig) state_d = S_REQ;
      S_REQ: if (rd_en) begin
        state_d   = S_ACT;
        act_cnt_d = 2'd0;
      end
      S_ACT: begin
        if (act_cnt_q == 2'd0) begin
          rd_cmd_d  = CMD_ACT;
          rd_addr_d = row_addr_q;
        end
        act_cnt_d = act_cnt_q + 2'd1;
        if (act_cnt_q == 2'd3) begin
          state_d     = S_READ;
          burst_cnt_d = 2'd0;
        end
      end
      S_READ: begin
        burst_cnt_d = burst_cnt_q + 2'd1;
        if (burst_cnt_q == 2'd0) begin
          rd_cmd_d   = CMD_RD;
          rd_addr_d  = {3'b000, col_addr_q};
          col_addr_d = col_addr_q + 9'd4;
          if (col_addr_q == 9'd508) row_addr_d = row_addr_q + 12'd1;
        end
        if (burst_cnt_q == 2'd3 && (ref_req || row_wrapped || all_read)) begin
          state_d     = S_BREAK;
          break_cnt_d = 3'd0;
          ref_pend_d  = ref_req;
          job_done_d  = all_read;
        end
      end
      S_BREAK: begin
        if (break_cnt_q == 3'd0) rd_cmd_d = CMD_PRE;
        break_cnt_d = break_cnt_q + 3'd1;
        if (break_cnt_q == 3'd4) begin
          break_cnt_d = 3'd0;
          act_cnt_d   = 2'd0;
          ref_pend_d  = 1'b0;
          job_done_d  = 1'b0;
          if (job_done_q) begin
            state_d    = S_IDLE;
            row_addr_d = 12'd0;
            col_addr_d = 9'd0;
            flag_d     = 1'b1;
          end else if (ref_pend_q) begin
            state_d = S_REQ;
            flag_d  = 1'b1;
          end else begin
            state_d = S_ACT;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        act_cnt_d   = 2'd0;
        burst_cnt_d = 2'd0;
        break_cnt_d = 3'd0;
      end
    endcase
    rd_req_d = (state_d == S_REQ);
  end

  // CL=3 plus the input register: DQ is captured 3..6 cycles after RD shows
  // on rd_cmd, giving rd_data_vld 4..7 cycles after it.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[RD_PIPE-1:0], rd_cmd_q == CMD_RD};
    cap_en     = |vld_pipe_q[RD_PIPE:2];
    rd_data_d  = cap_en ? rd_dq : rd_data_q;
    rd_vld_d   = cap_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      act_cnt_q   <= '0;
      burst_cnt_q <= '0;
      break_cnt_q <= '0;
      row_addr_q  <= '0;
      col_addr_q  <= '0;
      ref_pend_q  <= 1'b0;
      job_done_q  <= 1'b0;
      rd_cmd_q    <= CMD_NOP;
      rd_addr_q   <= ADDR_NOP;
      rd_req_q    <= 1'b0;
      flag_q      <= 1'b0;
      vld_pipe_q  <= '0;
      rd_data_q   <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_cnt_q   <= act_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      break_cnt_q <= break_cnt_d;
      row_addr_q  <= row_addr_d;
      col_addr_q  <= col_addr_d;
      ref_pend_q  <= ref_pend_d;
      job_done_q  <= job_done_d;
      rd_cmd_q    <= rd_cmd_d;
      rd_addr_q   <= rd_addr_d;
      rd_req_q    <= rd_req_d;
      flag_q      <= flag_d;
      vld_pipe_q  <= vld_pipe_d;
      rd_data_q   <= rd_data_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  assign rd_req      = rd_req_q;
  assign flag_rd_end = flag_q;
  assign rd_cmd      = rd_cmd_q;
  assign rd_addr     = rd_addr_q;
  assign bank_addr   = 2'b00;
  assign rd_data     = rd_data_q;
  assign rd_data_vld = rd_vld_q;

endmodule

// File: tb/tb_sdram_read.sv
// -----------------------------------------------------------------------------
// tb_sdram_read
//   Drives sdram_read with jobs, refresh requests and resets. A job-level model
//   (next unread row/column, an SDRAM that returns random words CL=3 after each
//   RD) checks every command, address and data beat.
// -----------------------------------------------------------------------------
module tb_sdram_read;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_trig = 1'b0;
  logic        rd_en = 1'b0;
  logic        ref_req = 1'b0;
  logic [15:0] rd_dq = '0;
  logic        rd_req, flag_rd_end, rd_data_vld;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  bank_addr;
  logic [15:0] rd_data;

  always #5 clk = ~clk;

  sdram_read dut (
    .clk(clk), .rst_n(rst_n), .rd_trig(rd_trig), .rd_en(rd_en),
    .ref_req(ref_req), .rd_dq(rd_dq), .rd_req(rd_req),
    .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
    .bank_addr(bank_addr), .rd_data(rd_data), .rd_data_vld(rd_data_vld)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model state
  int          cyc = 0;
  logic [15:0] dq_at[int];   // word the SDRAM drives during a cycle
  logic [15:0] exp_at[int];  // word expected on rd_data during a cycle
  int exp_row = 0, exp_col = 0, open_row = -1;
  int gcnt = 0, gdelay = 2;
  int n_act = 0, n_rd = 0, n_pre = 0, n_flag = 0, n_beat = 0, n_jobs = 0, n_refsvc = 0;
  bit fixed_next = 0, ref_col40 = 0, ref_last = 0, ref_rand = 0, rst_mark = 0, rst_hit = 0;

  task automatic monitor();
    logic [15:0] w;
    if (!rst_n) begin
      dq_at.delete(); exp_at.delete();
      exp_row = 0; exp_col = 0; open_row = -1;
      ref_req = 0; rd_en = 0; gcnt = 0; rd_dq = '0;
      return;
    end
    rd_dq = dq_at.exists(cyc) ? dq_at[cyc] : 16'($urandom);
    if (dq_at.exists(cyc)) dq_at.delete(cyc);
    chk("vld", rd_data_vld, exp_at.exists(cyc));
    if (rd_data_vld) n_beat++;
    if (exp_at.exists(cyc)) begin
      if (rd_data_vld) chk("rd_data", rd_data, exp_at[cyc]);
      exp_at.delete(cyc);
    end
    case (rd_cmd)
      4'b0011: begin
        chk("act_row", rd_addr, exp_row);
        chk("act_bank", bank_addr, 0);
        open_row = int'(rd_addr);
        n_act++;
      end
      4'b0101: begin
        chk("rd_addr", rd_addr, exp_col);
        chk("rd_row", open_row, exp_row);
        chk("rd_bank", bank_addr, 0);
        for (int k = 0; k < 4; k++) begin
          w = fixed_next ? 16'(3 + 2 * k) : 16'($urandom);
          dq_at[cyc + 3 + k]  = w;
          exp_at[cyc + 4 + k] = w;
        end
        fixed_next = 0;
        if (!ref_req && ((ref_col40 && exp_row == 0 && exp_col == 40) ||
                         (ref_last && exp_row == 1 && exp_col == 508) ||
                         (ref_rand && $urandom_range(0, 39) == 0)))
          ref_req = 1;
        if (rst_mark && exp_row == 1 && exp_col == 100) rst_hit = 1;
        exp_col += 4;
        if (exp_col == 512) begin
          exp_col = 0;
          exp_row++;
        end
        n_rd++;
      end
      4'b0010: begin
        chk("pre_addr", rd_addr, 12'h400);
        n_pre++;
      end
      4'b0111: chk("nop_addr", rd_addr, 12'h400);
      default: chk("cmd", rd_cmd, 4'b0111);
    endcase
    if (flag_rd_end) begin
      n_flag++;
      if (exp_row == 2) begin
        chk("end_rd_req", rd_req, 0);
        exp_row = 0; exp_col = 0;
        n_jobs++;
      end else begin
        chk("flag_ref", ref_req, 1);
        chk("ref_rd_req", rd_req, 1);
        n_refsvc++;
      end
      ref_req = 0;
    end
    if (rd_req) begin
      gcnt++;
      rd_en = (gcnt >= gdelay);
    end else begin
      gcnt = 0;
      rd_en = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd"}, rd_cmd, 4'b0111);
    chk({tag, "_addr"}, rd_addr, 12'h400);
    chk({tag, "_req"}, rd_req, 0);
    chk({tag, "_flag"}, flag_rd_end, 0);
    chk({tag, "_data"}, rd_data, 0);
    chk({tag, "_vld"}, rd_data_vld, 0);
  endtask

  int s_act, s_rd, s_pre, s_flag, s_beat, s_ref;

  task automatic run_job(input string tag, input bit mid_trig);
    int j0;
    bit done;
    s_act = n_act; s_rd = n_rd; s_pre = n_pre; s_flag = n_flag; s_beat = n_beat; s_ref = n_refsvc;
    j0 = n_jobs;
    done = 0;
    rd_trig = 1; step(); rd_trig = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      if (mid_trig && n_rd == s_rd + 50) begin
        rd_trig = 1; step(); rd_trig = 0;
      end else step();
      done = (n_jobs != j0);
    end
    chk({tag, "_timeout"}, done, 1);
    repeat (10) step();
    chk({tag, "_idle_req"}, rd_req, 0);
    chk({tag, "_rds"}, n_rd - s_rd, 256);
    chk({tag, "_beats"}, n_beat - s_beat, 1024);
    chk({tag, "_flags"}, n_flag - s_flag, 1 + n_refsvc - s_ref);
  endtask

  initial begin
    bit hit;
    repeat (3) step();
    chk_reset_outs("rst");
    chk("rst_bank", bank_addr, 0);
    rst_n = 1;
    repeat (3) step();

    // plain job, first burst returns 3,5,7,9
    fixed_next = 1; gdelay = 2;
    run_job("plain", 0);
    chk("plain_acts", n_act - s_act, 2);
    chk("plain_pres", n_pre - s_pre, 2);
    chk("plain_flags1", n_flag - s_flag, 1);

    // refresh at col 40 of row 0, plus a stray rd_trig mid-read
    ref_col40 = 1;
    run_job("ref40", 1);
    ref_col40 = 0;
    chk("ref40_svc", n_refsvc - s_ref, 1);
    chk("ref40_acts", n_act - s_act, 3);
    chk("ref40_pres", n_pre - s_pre, 3);

    // random refreshes and grant delays, refresh on the very last burst
    ref_rand = 1; ref_last = 1; gdelay = 1 + $urandom_range(0, 4);
    run_job("rand", 0);
    ref_rand = 0; ref_last = 0; gdelay = 2;

    // reset in the middle of row 1
    rst_mark = 1; rst_hit = 0; hit = 0;
    rd_trig = 1; step(); rd_trig = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      step();
      hit = rst_hit;
    end
    chk("midrst_reached", hit, 1);
    rst_mark = 0; rst_hit = 0;
    rst_n = 0;
    #1;
    chk_reset_outs("midrst");
    repeat (3) step();
    rst_n = 1;
    repeat (2) step();

    // fresh job after the reset must restart at row 0, col 0
    run_job("after_rst", 0);
    chk("after_rst_acts", n_act - s_act, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_read.md
SDRAM_READ -- requirements
Module: sdram_read

Interface
REQ-001 The block SHALL use one clock, clk; reset SHALL be rst_n, asynchronous and active-low.
REQ-002 Ports (name direction width meaning):
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- rd_trig  in  1  start a read job (pulse)
- rd_en  in  1  bus grant from arbiter
- ref_req  in  1  refresh request pending
- rd_dq  in  16  SDRAM DQ sampled data
- rd_req  out  1  bus request to arbiter
- flag_rd_end  out  1  one-cycle pulse: bus released
- rd_cmd  out  4  {CS,RAS,CAS,WE}
- rd_addr  out  12  SDRAM A[11:0]
- bank_addr  out  2  bank select, constant 2'b00
- rd_data  out  16  captured read word
- rd_data_vld  out  1  rd_data valid

Function
REQ-003 Commands SHALL be NOP=0111, ACT=0011, RD=0101, PRE=0010.
REQ-004 FSM states SHALL be IDLE, REQ, ACT, READ, BREAK, one-hot; illegal encodings SHALL go to IDLE.
REQ-005 IDLE->REQ on rd_trig; rd_trig outside IDLE SHALL be ignored.
REQ-006 rd_req SHALL be high exactly while in REQ; REQ->ACT when rd_en=1.
REQ-007 ACT SHALL last 4 cycles (act_cnt 0..3); ACT is issued at act_cnt=0, NOP otherwise; ACT->READ after act_cnt=3.
REQ-008 READ SHALL run 4-cycle burst slots (burst_cnt 0..3, 2-bit wrap); RD is issued at burst_cnt=0, NOP otherwise; burst length 4, CAS latency 3.
REQ-009 Exit decisions SHALL be taken only at burst_cnt=3; a burst is never truncated.
REQ-010 At burst_cnt=3, READ->BREAK if ref_req=1, last column of the row, or last burst of the job; otherwise READ continues.
REQ-011 BREAK SHALL last 5 cycles (break_cnt 0..4); PRE is issued at break_cnt=0, NOP otherwise.
REQ-012 At break_cnt=4, priority: job done->IDLE; else refresh latched at READ exit->REQ; else->ACT (row change).
REQ-013 flag_rd_end SHALL pulse one cycle on the BREAK->IDLE and BREAK->REQ transitions only.
REQ-014 rd_cmd and rd_addr SHALL be registered and present one cycle after the state/counter condition that selects them.
REQ-015 rd_addr SHALL be row_addr with ACT, {3'b000,col_addr} with RD (A10=0, no auto-precharge), and 12'h400 with PRE and NOP.
REQ-016 col_addr is 9 bits and SHALL advance by 4 after each issued RD.
REQ-017 After the RD at col_addr=508, col_addr SHALL wrap to 0 and row_addr (12 bits) SHALL increment.
REQ-018 A job SHALL read rows 0 and 1, 512 words each (256 bursts); the last burst is row 1, col 508.
REQ-019 After a refresh break, the job SHALL resume at the next unread burst address.
REQ-020 At job end, row_addr and col_addr SHALL clear to 0.
REQ-021 rd_data/rd_data_vld SHALL be registered from rd_dq: vld high for 4 consecutive cycles starting 4 cycles after each RD appears on rd_cmd.
REQ-022 In-flight burst data SHALL complete during BREAK, since PRE issues after the last data beat is launched.
REQ-023 ref_req asserted in REQ or ACT SHALL NOT abort those states.

Reset
REQ-024 On rst_n low, state SHALL be IDLE, rd_cmd=NOP, rd_addr=12'h400, and all counters 0.
REQ-025 On rst_n low, rd_req=0, flag_rd_end=0, rd_data=0, rd_data_vld=0.
REQ-026 A mid-job reset SHALL abandon the job; the next rd_trig SHALL restart at row 0, col 0.

Verification
REQ-027 rd_trig, rd_en 2 cycles later, no ref_req -> ACT row 0, then 128 RDs col 0,4..508, PRE, ACT row 1, 128 RDs, PRE, IDLE, one flag_rd_end, 1024 vld beats.
REQ-028 Single burst, model returns 3,5,7,9 -> rd_data_vld high 4 cycles beginning 4 cycles after RD; rd_data=3,5,7,9 in order.
REQ-029 ref_req raised at burst_cnt=1 of RD col 40 -> burst completes, PRE, flag_rd_end pulse, rd_req high; after regrant -> ACT same row, next RD col 44.
REQ-030 rd_trig pulsed during READ -> no effect; job ends normally after 256 bursts.
REQ-031 rst_n low during READ row 1 -> all outputs at reset values immediately; new rd_trig -> first ACT row 0, first RD col 0.
REQ-032 ref_req and last burst (row 1 col 508) coincide -> BREAK->IDLE, single flag_rd_end, rd_req stays low.
